// File: rtl/sqrt_pkg.sv
// sqrt_pkg: shared definitions for the sequential integer square root.
//   state_e   - controller states (IDLE, ITER, DONE)
//   rw_f      - root width for a given radicand width
//   sq_w_f    - width of the running odd-sum (square) register
//   del_w_f   - width of the odd-increment register
package sqrt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int unsigned rw_f(input int unsigned w);
    return w / 2;
  endfunction

  // One extra bit so the square can step past 2^WIDTH-1 without wrapping.
  function automatic int unsigned sq_w_f(input int unsigned w);
    return w + 1;
  endfunction

  // Increment reaches 2*(2^RW)+1, which needs RW+2 bits.
  function automatic int unsigned del_w_f(input int unsigned w);
    return (w / 2) + 2;
  endfunction

endpackage

// File: rtl/sqrt_datapath.sv
// sqrt_datapath: odd-number summation datapath for sqrt_seq.
//   Holds the captured radicand, the running square (sum of odd numbers),
//   the next odd increment, the comparator and the result registers.
// Ports:
//   clk, clr   - clock, synchronous active-high clear of all registers
//   load_i     - capture a_i and initialise square=1, increment=3
//   step_i     - advance square by increment, increment by 2
//   cap_i      - register the root (and remainder) from current state
//   a_i        - radicand
//   greater_o  - square exceeds captured radicand (unsigned, full width)
//   sqrt_o     - registered root
//   rem_o      - registered remainder (only with SQRT_REM_EN defined)
// Macro: SQRT_REM_EN enables the remainder register and port.
module sqrt_datapath
  import sqrt_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic                     load_i,
  input  logic                     step_i,
  input  logic                     cap_i,
  input  logic [WIDTH-1:0]         a_i,
  output logic                     greater_o,
  output logic [rw_f(WIDTH)-1:0]   sqrt_o
`ifdef SQRT_REM_EN
  ,
  output logic [rw_f(WIDTH):0]     rem_o
`endif
);

  localparam int unsigned RW   = rw_f(WIDTH);
  localparam int unsigned SQW  = sq_w_f(WIDTH);
  localparam int unsigned DELW = del_w_f(WIDTH);

  logic [WIDTH-1:0] a_q,    a_d;
  logic [SQW-1:0]   sq_q,   sq_d;
  logic [DELW-1:0]  del_q,  del_d;
  logic [RW-1:0]    sqrt_q, sqrt_d;

  assign greater_o = sq_q > SQW'(a_q);
  assign sqrt_o    = sqrt_q;

  always_comb begin
    a_d    = a_q;
    sq_d   = sq_q;
    del_d  = del_q;
    sqrt_d = sqrt_q;
    if (load_i) begin
      a_d   = a_i;
      sq_d  = SQW'(1);
      del_d = DELW'(3);
    end else if (step_i) begin
      sq_d  = sq_q + SQW'(del_q);
      del_d = del_q + DELW'(2);
    end
    // Increment is 2*(root+1)+1 when the square first overshoots.
    if (cap_i) begin
      sqrt_d = RW'((del_q >> 1) - DELW'(1));
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      a_q    <= '0;
      sq_q   <= '0;
      del_q  <= '0;
      sqrt_q <= '0;
    end else begin
      a_q    <= a_d;
      sq_q   <= sq_d;
      del_q  <= del_d;
      sqrt_q <= sqrt_d;
    end
  end

`ifdef SQRT_REM_EN
  localparam int unsigned REMW = RW + 1;

  logic [REMW-1:0] rem_q, rem_d;

  // sq_q - del_q + 2 is the previous square, i.e. root^2.
  always_comb begin
    rem_d = rem_q;
    if (cap_i) begin
      rem_d = REMW'(SQW'(a_q) - sq_q + SQW'(del_q) - SQW'(2));
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      rem_q <= '0;
    end else begin
      rem_q <= rem_d;
    end
  end

  assign rem_o = rem_q;
`endif

endmodule

// File: rtl/sqrt_seq.sv
// sqrt_seq: sequential integer square root by odd-number summation.
//   Accepts a radicand on start in IDLE, iterates root+1 cycles, then
//   pulses done for one cycle; the root is held until the next accept.
// Ports:
//   clk    - clock (rising edge)
//   clr    - synchronous active-high reset, aborts any computation
//   start  - request, sampled only in IDLE
//   a      - radicand (WIDTH bits, unsigned)
//   busy   - computation in progress
//   done   - one-cycle result-valid pulse
//   sqrt   - floor(sqrt(a)) (WIDTH/2 bits)
//   rem    - a - sqrt^2 (WIDTH/2+1 bits), present only with SQRT_REM_EN
// Macro: SQRT_REM_EN enables the remainder output.
module sqrt_seq
  import sqrt_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   clr,
  input  logic                   start,
  input  logic [WIDTH-1:0]       a,
  output logic                   busy,
  output logic                   done,
  output logic [rw_f(WIDTH)-1:0] sqrt
`ifdef SQRT_REM_EN
  ,
  output logic [rw_f(WIDTH):0]   rem
`endif
);

  if ((WIDTH < 2) || ((WIDTH % 2) != 0)) begin : g_width_chk
    $error("sqrt_seq: WIDTH must be even and at least 2");
  end

  state_e state_q, state_d;
  logic   greater;
  logic   load, step, cap;

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = ITER;
      ITER:    if (greater) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    load = 1'b0;
    step = 1'b0;
    cap  = 1'b0;
    unique case (state_q)
      IDLE: load = start;
      ITER: begin
        busy = 1'b1;
        cap  = greater;
        step = ~greater;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  sqrt_datapath #(
    .WIDTH(WIDTH)
  ) u_dp (
    .clk       (clk),
    .clr       (clr),
    .load_i    (load),
    .step_i    (step),
    .cap_i     (cap),
    .a_i       (a),
    .greater_o (greater),
    .sqrt_o    (sqrt)
`ifdef SQRT_REM_EN
    ,
    .rem_o     (rem)
`endif
  );

endmodule

// File: tb/tb_sqrt_seq.sv
// tb_sqrt_seq: directed self-checking bench for sqrt_seq (WIDTH=8 plus a
// WIDTH=16 instance). Remainder checks apply when SQRT_REM_EN is defined.
module tb_sqrt_seq;

  logic       clk = 1'b0;
  logic       clr;
  logic       start;
  logic [7:0] a;
  logic       busy, done;
  logic [3:0] sqrt_o;
  logic        start16;
  logic [15:0] a16;
  logic        busy16, done16;
  logic [7:0]  sqrt16;
`ifdef SQRT_REM_EN
  logic [4:0] rem_o;
  logic [8:0] rem16;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sqrt_seq #(.WIDTH(8)) dut (
    .clk   (clk),
    .clr   (clr),
    .start (start),
    .a     (a),
    .busy  (busy),
    .done  (done),
    .sqrt  (sqrt_o)
`ifdef SQRT_REM_EN
    ,
    .rem   (rem_o)
`endif
  );

  sqrt_seq #(.WIDTH(16)) dut16 (
    .clk   (clk),
    .clr   (clr),
    .start (start16),
    .a     (a16),
    .busy  (busy16),
    .done  (done16),
    .sqrt  (sqrt16)
`ifdef SQRT_REM_EN
    ,
    .rem   (rem16)
`endif
  );

  // Drive one request on the 8-bit DUT; lat counts negedges after the accept
  // edge up to and including the one where done is seen high.
  task automatic do_op(input logic [7:0] val, output int lat, output bit got,
                       output bit busy1);
    @(negedge clk);
    a = val;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = ~val;
    lat = 0;
    got = 1'b0;
    busy1 = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      lat++;
      if (i == 0) busy1 = busy;
      if (done) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_op16(input logic [15:0] val, output int lat, output bit got);
    @(negedge clk);
    a16 = val;
    start16 = 1'b1;
    @(posedge clk);
    #1;
    start16 = 1'b0;
    a16 = ~val;
    lat = 0;
    got = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      lat++;
      if (done16) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    clr = 1'b1;
    start = 1'b1;
    a = 8'd9;
    repeat (3) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_checks++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
    n_checks++;
    if (sqrt_o !== 4'd0) begin n_fail++; $display("FAIL reset_sqrt got %0d want 0", sqrt_o); end
`ifdef SQRT_REM_EN
    n_checks++;
    if (rem_o !== 5'd0) begin n_fail++; $display("FAIL reset_rem got %0d want 0", rem_o); end
`endif
    clr = 1'b0;
    start = 1'b0;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_start_ignored busy got %b want 0", busy); end
  endtask

  task automatic test_basic();
    logic [7:0] vals [5] = '{8'd10, 8'd16, 8'd15, 8'd0, 8'd255};
    logic [3:0] exp_s [5] = '{4'd3, 4'd4, 4'd3, 4'd0, 4'd15};
    logic [4:0] exp_r [5] = '{5'd1, 5'd0, 5'd6, 5'd0, 5'd30};
    int         exp_l [5] = '{5, 6, 5, 2, 17};
    int lat;
    bit got, b1;
    for (int i = 0; i < 5; i++) begin
      do_op(vals[i], lat, got, b1);
      n_checks++;
      if (!got) begin n_fail++; $display("FAIL basic_done a=%0d no done within bound", vals[i]); end
      n_checks++;
      if (lat != exp_l[i]) begin n_fail++; $display("FAIL basic_latency a=%0d got %0d want %0d", vals[i], lat, exp_l[i]); end
      n_checks++;
      if (b1 !== 1'b1) begin n_fail++; $display("FAIL basic_busy a=%0d got %b want 1", vals[i], b1); end
      n_checks++;
      if (sqrt_o !== exp_s[i]) begin n_fail++; $display("FAIL basic_sqrt a=%0d got %0d want %0d", vals[i], sqrt_o, exp_s[i]); end
`ifdef SQRT_REM_EN
      n_checks++;
      if (rem_o !== exp_r[i]) begin n_fail++; $display("FAIL basic_rem a=%0d got %0d want %0d", vals[i], rem_o, exp_r[i]); end
`endif
      @(negedge clk);
      n_checks++;
      if (done !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse a=%0d done still %b want 0", vals[i], done); end
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (sqrt_o !== 4'd15) begin n_fail++; $display("FAIL basic_hold got %0d want 15", sqrt_o); end
  endtask

  task automatic test_ignore_start();
    int dones = 0;
    @(negedge clk);
    a = 8'd100;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = 8'd3;
    @(negedge clk);
    @(negedge clk);
    a = 8'd4;
    start = 1'b1;
    @(negedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done) dones++;
    end
    n_checks++;
    if (dones != 1) begin n_fail++; $display("FAIL ignore_done_count got %0d want 1", dones); end
    n_checks++;
    if (sqrt_o !== 4'd10) begin n_fail++; $display("FAIL ignore_sqrt got %0d want 10", sqrt_o); end
`ifdef SQRT_REM_EN
    n_checks++;
    if (rem_o !== 5'd0) begin n_fail++; $display("FAIL ignore_rem got %0d want 0", rem_o); end
`endif
  endtask

  task automatic test_clr_abort();
    int dones = 0;
    int lat;
    bit got, b1;
    @(negedge clk);
    a = 8'd200;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    clr = 1'b1;
    start = 1'b1;
    a = 8'd77;
    @(negedge clk);
    clr = 1'b0;
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL clr_busy got %b want 0", busy); end
    n_checks++;
    if (sqrt_o !== 4'd0) begin n_fail++; $display("FAIL clr_sqrt got %0d want 0", sqrt_o); end
`ifdef SQRT_REM_EN
    n_checks++;
    if (rem_o !== 5'd0) begin n_fail++; $display("FAIL clr_rem got %0d want 0", rem_o); end
`endif
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done || busy) dones++;
    end
    n_checks++;
    if (dones != 0) begin n_fail++; $display("FAIL clr_no_done activity %0d want 0", dones); end
    do_op(8'd49, lat, got, b1);
    n_checks++;
    if (!got || lat != 9) begin n_fail++; $display("FAIL clr_restart_latency got %0d (done %b) want 9", lat, got); end
    n_checks++;
    if (sqrt_o !== 4'd7) begin n_fail++; $display("FAIL clr_restart_sqrt got %0d want 7", sqrt_o); end
  endtask

  task automatic test_back_to_back();
    int cnt = 0;
    int first = 0;
    int last = 0;
    int bad_gap = 0;
    @(negedge clk);
    a = 8'd10;
    start = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (done) begin
        if (cnt == 0) first = i;
        else if (i - last != 6) bad_gap++;
        last = i;
        cnt++;
      end
    end
    start = 1'b0;
    repeat (10) @(negedge clk);
    n_checks++;
    if (cnt != 6) begin n_fail++; $display("FAIL b2b_count got %0d want 6", cnt); end
    n_checks++;
    if (first != 5) begin n_fail++; $display("FAIL b2b_first got %0d want 5", first); end
    n_checks++;
    if (bad_gap != 0) begin n_fail++; $display("FAIL b2b_gap bad gaps %0d want 0", bad_gap); end
    n_checks++;
    if (sqrt_o !== 4'd3) begin n_fail++; $display("FAIL b2b_sqrt got %0d want 3", sqrt_o); end
  endtask

  task automatic test_sweep();
    int lat, r;
    bit got, b1;
    for (int v = 0; v < 256; v++) begin
      r = 0;
      while ((r + 1) * (r + 1) <= v) r++;
      do_op(8'(v), lat, got, b1);
      n_checks++;
      if (!got || lat != r + 2) begin n_fail++; $display("FAIL sweep_latency a=%0d got %0d want %0d", v, lat, r + 2); end
      n_checks++;
      if (sqrt_o !== 4'(r)) begin n_fail++; $display("FAIL sweep_sqrt a=%0d got %0d want %0d", v, sqrt_o, r); end
`ifdef SQRT_REM_EN
      n_checks++;
      if (rem_o !== 5'(v - r * r)) begin n_fail++; $display("FAIL sweep_rem a=%0d got %0d want %0d", v, rem_o, v - r * r); end
`endif
    end
  endtask

  task automatic test_wide();
    logic [15:0] vals [3] = '{16'd65535, 16'd1000, 16'd256};
    logic [7:0]  exp_s [3] = '{8'd255, 8'd31, 8'd16};
    logic [8:0]  exp_r [3] = '{9'd510, 9'd39, 9'd0};
    int lat;
    bit got;
    for (int i = 0; i < 3; i++) begin
      do_op16(vals[i], lat, got);
      n_checks++;
      if (!got || lat != int'(exp_s[i]) + 2) begin n_fail++; $display("FAIL wide_latency a=%0d got %0d want %0d", vals[i], lat, int'(exp_s[i]) + 2); end
      n_checks++;
      if (sqrt16 !== exp_s[i]) begin n_fail++; $display("FAIL wide_sqrt a=%0d got %0d want %0d", vals[i], sqrt16, exp_s[i]); end
`ifdef SQRT_REM_EN
      n_checks++;
      if (rem16 !== exp_r[i]) begin n_fail++; $display("FAIL wide_rem a=%0d got %0d want %0d", vals[i], rem16, exp_r[i]); end
`endif
    end
  endtask

  initial begin
    clr = 1'b1;
    start = 1'b0;
    a = '0;
    start16 = 1'b0;
    a16 = '0;
    test_reset();
    test_basic();
    test_ignore_start();
    test_clr_abort();
    test_back_to_back();
    test_sweep();
    test_wide();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
